// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the set of legal byte-lane masks.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic [3:0] MASK_B0  = 4'b0001;
   localparam logic [3:0] MASK_B1  = 4'b0010;
   localparam logic [3:0] MASK_B2  = 4'b0100;
   localparam logic [3:0] MASK_B3  = 4'b1000;
   localparam logic [3:0] MASK_HLO = 4'b0011;
   localparam logic [3:0] MASK_HHI = 4'b1100;
   localparam logic [3:0] MASK_W   = 4'b1111;

   // Only naturally aligned byte, halfword and word lane patterns are accepted.
   function automatic logic mask_legal(input logic [3:0] mask);
      case (mask)
         MASK_B0, MASK_B1, MASK_B2, MASK_B3,
         MASK_HLO, MASK_HHI, MASK_W: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: per-lane synchronous write and an
// enabled registered read port that holds its value between reads.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic          i_re,
   input  logic [AW-1:0] i_idx,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
               r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side endpoint for byte-masked load/store requests: one request at a
// time, fixed wait-state delay, lane-merged writes, full-word reads, error flag.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_mask,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_t r_state;
   dmem_state_t w_nextState;
   logic [3:0]  r_count;
   logic        r_we;
   logic [29:0] r_idx;
   logic [3:0]  r_mask;
   logic [31:0] r_wdata;
   logic        r_respLoad;
   logic        r_respErr;

   logic        w_accept;
   logic        w_enterResp;
   logic        w_opFromReq;
   logic        w_opWe;
   logic [29:0] w_opIdx;
   logic [3:0]  w_opMask;
   logic [31:0] w_opWdata;
   logic        w_opErr;
   logic        w_arrWe;
   logic        w_arrRe;
   logic [31:0] w_arrRdata;
   logic        w_unusedAddrBits;

   assign w_unusedAddrBits = ^req_addr[1:0];

   assign req_ready   = (r_state == IDLE) && !rst;
   assign w_accept    = req_ready && req_valid;
   assign w_enterResp = (w_accept && (WAIT_STATES == 0)) ||
                        ((r_state == WAIT) && (r_count == 4'd0));

   // With zero wait states the access fires on the accepting edge, so the
   // operands come straight from the request rather than the latched copy.
   assign w_opFromReq = (r_state == IDLE);
   assign w_opWe      = w_opFromReq ? req_we          : r_we;
   assign w_opIdx     = w_opFromReq ? req_addr[31:2]  : r_idx;
   assign w_opMask    = w_opFromReq ? req_mask        : r_mask;
   assign w_opWdata   = w_opFromReq ? req_wdata       : r_wdata;
   assign w_opErr     = !mask_legal(w_opMask) ||
                        ({2'b00, w_opIdx} >= 32'(DEPTH_WORDS));

   assign w_arrWe = w_enterResp && !rst && w_opWe  && !w_opErr;
   assign w_arrRe = w_enterResp && !rst && !w_opWe && !w_opErr;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:    if (r_count == 4'd0) w_nextState = RESP;
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_count    <= 4'd0;
         r_respLoad <= 1'b0;
         r_respErr  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_we    <= req_we;
            r_idx   <= req_addr[31:2];
            r_mask  <= req_mask;
            r_wdata <= req_wdata;
            r_count <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
         end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
         end
         if (w_enterResp) begin
            r_respLoad <= !w_opWe && !w_opErr;
            r_respErr  <= w_opErr;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) uArray (
      .clk     (clk),
      .i_we    (w_arrWe),
      .i_be    (w_opMask),
      .i_re    (w_arrRe),
      .i_idx   (w_opIdx[AW-1:0]),
      .i_wdata (w_opWdata),
      .o_rdata (w_arrRdata)
   );

   assign resp_valid = (r_state == RESP) && !rst;
   assign resp_rdata = r_respLoad ? w_arrRdata : 32'd0;
   assign resp_err   = r_respErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) driven
// by directed and random requests, checked against a word-array model.
module tb_dmem_responder;

   localparam int NI    = 3;
   localparam int DEPTH = 16;

   logic        clk;
   logic        rst       [NI];
   logic        reqValid  [NI];
   logic        reqReady  [NI];
   logic        reqWe     [NI];
   logic [31:0] reqAddr   [NI];
   logic [3:0]  reqMask   [NI];
   logic [31:0] reqWdata  [NI];
   logic        respValid [NI];
   logic [31:0] respRdata [NI];
   logic        respErr   [NI];

   logic [31:0] modelMem [NI][DEPTH];
   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NI; g++) begin : gDut
      dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 1 : 3)
      ) uDut (
         .clk        (clk),
         .rst        (rst[g]),
         .req_valid  (reqValid[g]),
         .req_ready  (reqReady[g]),
         .req_we     (reqWe[g]),
         .req_addr   (reqAddr[g]),
         .req_mask   (reqMask[g]),
         .req_wdata  (reqWdata[g]),
         .resp_valid (respValid[g]),
         .resp_rdata (respRdata[g]),
         .resp_err   (respErr[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wsOf(input int inst);
      return (inst == 0) ? 0 : (inst == 1) ? 1 : 3;
   endfunction

   function automatic bit legalMask(input logic [3:0] m);
      return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete request, entered and left in an idle cycle just after a clock edge.
   task automatic applyStimulus(input int inst, input logic we, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] wdata);
      int          ws;
      int          idx;
      bit          expErr;
      logic [31:0] expData;
      ws      = wsOf(inst);
      idx     = int'(addr >> 2);
      expErr  = !legalMask(mask) || ((addr >> 2) >= DEPTH);
      expData = (!expErr && !we) ? modelMem[inst][idx] : 32'd0;
      reqValid[inst] = 1'b1;
      reqWe[inst]    = we;
      reqAddr[inst]  = addr;
      reqMask[inst]  = mask;
      reqWdata[inst] = wdata;
      #1;
      checkOutput($sformatf("i%0d_ready_idle", inst), 32'(reqReady[inst]), 32'd1);
      @(posedge clk); #1;
      reqValid[inst] = 1'b0;
      reqWe[inst]    = ~we;
      reqAddr[inst]  = $urandom();
      reqMask[inst]  = 4'($urandom());
      reqWdata[inst] = $urandom();
      for (int j = 0; j <= ws; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         checkOutput($sformatf("i%0d_ready_busy", inst), 32'(reqReady[inst]), 32'd0);
         if (j < ws) begin
            checkOutput($sformatf("i%0d_valid_wait", inst), 32'(respValid[inst]), 32'd0);
         end else begin
            checkOutput($sformatf("i%0d_valid_resp", inst), 32'(respValid[inst]), 32'd1);
            checkOutput($sformatf("i%0d_rdata", inst), respRdata[inst], expData);
            checkOutput($sformatf("i%0d_err", inst), 32'(respErr[inst]), 32'(expErr));
         end
      end
      @(posedge clk); #1;
      checkOutput($sformatf("i%0d_valid_after", inst), 32'(respValid[inst]), 32'd0);
      checkOutput($sformatf("i%0d_ready_after", inst), 32'(reqReady[inst]), 32'd1);
      checkOutput($sformatf("i%0d_rdata_hold", inst), respRdata[inst], expData);
      checkOutput($sformatf("i%0d_err_hold", inst), 32'(respErr[inst]), 32'(expErr));
      if (we && !expErr) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) modelMem[inst][idx][8*b +: 8] = wdata[8*b +: 8];
         end
      end
   endtask

   // Three loads with req_valid held high; checks accept spacing and one pulse per accept.
   task automatic holdLoads(input int inst, input logic [31:0] addr);
      int ws;
      int accepts;
      int pulses;
      int acceptCyc [3];
      ws      = wsOf(inst);
      accepts = 0;
      pulses  = 0;
      reqValid[inst] = 1'b1;
      reqWe[inst]    = 1'b0;
      reqAddr[inst]  = addr;
      reqMask[inst]  = 4'b1111;
      reqWdata[inst] = 32'd0;
      for (int cyc = 0; cyc < 40 && pulses < 3; cyc++) begin
         #1;
         if (respValid[inst]) begin
            checkOutput($sformatf("i%0d_b2b_ready_in_resp", inst), 32'(reqReady[inst]), 32'd0);
            checkOutput($sformatf("i%0d_b2b_rdata", inst), respRdata[inst], modelMem[inst][addr >> 2]);
            if (pulses < accepts) begin
               checkOutput($sformatf("i%0d_b2b_latency", inst), 32'(cyc), 32'(acceptCyc[pulses] + 1 + ws));
            end
            pulses++;
         end
         if (accepts == 3) reqValid[inst] = 1'b0;
         if (reqValid[inst] && reqReady[inst]) begin
            acceptCyc[accepts] = cyc;
            accepts++;
         end
         @(posedge clk);
      end
      #1;
      reqValid[inst] = 1'b0;
      checkOutput($sformatf("i%0d_b2b_accepts", inst), 32'(accepts), 32'd3);
      checkOutput($sformatf("i%0d_b2b_pulses", inst), 32'(pulses), 32'd3);
      if (accepts == 3) begin
         checkOutput($sformatf("i%0d_b2b_gap1", inst), 32'(acceptCyc[1] - acceptCyc[0]), 32'(ws + 2));
         checkOutput($sformatf("i%0d_b2b_gap2", inst), 32'(acceptCyc[2] - acceptCyc[1]), 32'(ws + 2));
      end
      checkOutput($sformatf("i%0d_b2b_idle", inst), 32'(reqReady[inst]), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst[i]      = 1'b1;
         reqValid[i] = 1'b0;
         reqWe[i]    = 1'b0;
         reqAddr[i]  = 32'd0;
         reqMask[i]  = 4'd0;
         reqWdata[i] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("i%0d_rst_ready", i), 32'(reqReady[i]), 32'd0);
         checkOutput($sformatf("i%0d_rst_valid", i), 32'(respValid[i]), 32'd0);
         checkOutput($sformatf("i%0d_rst_rdata", i), respRdata[i], 32'd0);
         checkOutput($sformatf("i%0d_rst_err", i), 32'(respErr[i]), 32'd0);
         rst[i] = 1'b0;
      end
      #1;
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("i%0d_ready_after_rst", i), 32'(reqReady[i]), 32'd1);
      end

      for (int i = 0; i < NI; i++) begin
         for (int a = 0; a < DEPTH; a++) applyStimulus(i, 1'b1, 32'(a * 4), 4'b1111, $urandom());
      end

      // Word store/load, then byte and halfword merges into the same word.
      applyStimulus(1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
      applyStimulus(1, 1'b0, 32'h10, 4'b1111, 32'h0);
      applyStimulus(1, 1'b1, 32'h10, 4'b0010, 32'h0000AA00);
      applyStimulus(1, 1'b1, 32'h13, 4'b1100, 32'h55660000);
      applyStimulus(1, 1'b0, 32'h10, 4'b0001, 32'h0);
      checkOutput("i1_merge_model", modelMem[1][4], 32'h5566AAEF);

      // Illegal mask and out-of-range address leave memory untouched.
      applyStimulus(1, 1'b1, 32'h10, 4'b0101, 32'hFFFFFFFF);
      applyStimulus(1, 1'b0, 32'h10, 4'b0101, 32'h0);
      applyStimulus(1, 1'b1, 32'(4 * DEPTH), 4'b1111, 32'hFFFFFFFF);
      applyStimulus(1, 1'b0, 32'(4 * DEPTH), 4'b1111, 32'h0);
      applyStimulus(1, 1'b0, 32'h10, 4'b1111, 32'h0);

      holdLoads(1, 32'h10);
      holdLoads(2, 32'h08);
      holdLoads(0, 32'h0C);

      // Reset in the second wait cycle aborts the store.
      reqValid[2] = 1'b1;
      reqWe[2]    = 1'b1;
      reqAddr[2]  = 32'h20;
      reqMask[2]  = 4'b1111;
      reqWdata[2] = 32'h12345678;
      @(posedge clk); #1;
      reqValid[2] = 1'b0;
      checkOutput("i2_abort_wait1", 32'(respValid[2]), 32'd0);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      #1;
      checkOutput("i2_abort_ready_in_rst", 32'(reqReady[2]), 32'd0);
      @(posedge clk); #1;
      rst[2] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         checkOutput("i2_abort_no_resp", 32'(respValid[2]), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("i2_abort_rdata_cleared", respRdata[2], 32'd0);
      applyStimulus(2, 1'b0, 32'h20, 4'b1111, 32'h0);

      // Reset during the response cycle still keeps the committed store.
      reqValid[1] = 1'b1;
      reqWe[1]    = 1'b1;
      reqAddr[1]  = 32'h24;
      reqMask[1]  = 4'b0011;
      reqWdata[1] = 32'hCAFEF00D;
      @(posedge clk); #1;
      reqValid[1] = 1'b0;
      @(posedge clk); #1;
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      modelMem[1][9][15:0] = 16'hF00D;
      #1;
      checkOutput("i1_resp_rst_err", 32'(respErr[1]), 32'd0);
      applyStimulus(1, 1'b0, 32'h24, 4'b1111, 32'h0);

      applyStimulus(0, 1'b1, 32'h18, 4'b1111, 32'h0BADF00D);
      applyStimulus(0, 1'b0, 32'h18, 4'b1111, 32'h0);

      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 30; n++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 4 * DEPTH - 1));
            applyStimulus(i, 1'($urandom()), addr, 4'($urandom()), $urandom());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the three-stage pipeline: the memory-side endpoint that services the byte-masked load/store requests produced by the execute-stage load/store sizing logic. It accepts one request at a time over a valid/ready handshake, applies a parameterised wait-state delay, commits byte-lane writes or returns the full aligned word, and flags illegal accesses. Load sign/zero extension stays on the requester side; this block always returns the full aligned word.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4
- `WAIT_STATES`, 1: extra cycles between acceptance and response; 0–15
- `clk` input 1: single clock, rising-edge
- `rst` input 1: reset, synchronous, active-high
- `req_valid` input 1: request present
- `req_ready` output 1: block can accept a request this cycle
- `req_we` input 1: 1 = store, 0 = load
- `req_addr` input 32: byte address; bits [1:0] ignored, word index = `req_addr[31:2]`
- `req_mask` input 4: byte-lane enables; bit i selects `req_wdata[8i+7:8i]`
- `req_wdata` input 32: lane-positioned store data
- `resp_valid` output 1: one-cycle response pulse
- `resp_rdata` output 32: read word; 0 for stores and errors
- `resp_err` output 1: access rejected; valid with `resp_valid`

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch we/word index/mask/wdata. If `WAIT_STATES`=0, go to RESP. Otherwise load the wait counter with `WAIT_STATES-1` and go to WAIT.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter is 0, go to RESP.
- Memory operation fires on the clock edge that enters RESP.
  - Store: write only lanes whose mask bit is 1; other lanes unchanged.
  - Load: register the full word into `resp_rdata`. The mask is checked for legality only.
- RESP: `resp_valid`=1 for exactly one cycle. No response backpressure. Next state is IDLE.
- Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Error: illegal mask, or word index ≥ `DEPTH_WORDS`. No array write, `resp_rdata`=0, `resp_err`=1.
- Stores that complete without error return `resp_rdata`=0 and `resp_err`=0.
- Request inputs are sampled only at acceptance; changes afterward have no effect.

## Timing
- Reset values: FSM=IDLE, counter=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. Memory contents are not cleared.
- `req_ready` is 0 in any cycle where `rst`=1, and goes high in the first cycle after `rst` falls.
- Latency: a request accepted in cycle N has `resp_valid` high in cycle N+1+`WAIT_STATES`.
- Throughput: one request per `WAIT_STATES`+2 cycles. `req_ready` returns in the cycle after RESP.
- `resp_rdata` and `resp_err` are registered and hold their values after the pulse until the next response or reset.
- Reset during WAIT aborts the access: no write occurs and no response is produced.
- Reset during RESP drops the remaining pulse. A store already committed on the RESP-entry edge stays written.
- Load after store to the same word: returns the updated data, since the store commits before the next acceptance.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum (`dmem_state_t`)
  - legal-mask constants `MASK_B0..MASK_B3`, `MASK_HLO`, `MASK_HHI`, `MASK_W`
  - function `mask_legal(logic [3:0])`
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage with synchronous write, per-lane write enable and registered read port. The FSM, counter and error check stay in `dmem_responder`.

## Test plan
- Reset, then store word 0xDEADBEEF, mask 1111, addr 0x10, with `WAIT_STATES`=1. Then load addr 0x10 → `resp_valid` two cycles after each acceptance; load returns 0xDEADBEEF with `resp_err`=0.
- Byte/half merge: after the word above, store 0x0000AA00 with mask 0010, then 0x55660000 with mask 1100 to 0x10. Load → 0x5566AAEF.
- Errors: request with mask 0101, or with addr = 4×`DEPTH_WORDS` → `resp_err`=1, `resp_rdata`=0, memory unchanged on a follow-up load.
- Back-to-back: hold `req_valid`=1 for 3 loads → `req_ready` high only in IDLE; accepts spaced `WAIT_STATES`+2 cycles apart; one `resp_valid` pulse per accept.
- Reset mid-WAIT (`WAIT_STATES`=3): accept store 0x12345678, assert `rst` in the second WAIT cycle → no `resp_valid`; a later load returns the old value.
- `WAIT_STATES`=0: store then load → `resp_valid` in the cycle after each acceptance; load data is correct.
